// File: rtl/preg_free_arbiter.sv
// Arbitrates ROB-commit and squash-walker PREG frees onto Rename's single free-list return port.
// Optional FREE_DUP_CHECK_EN adds a free bitmap that flags duplicate frees on dup_err_o.
module preg_free_arbiter #(
    parameter int N_PHYS     = 64,
    parameter int STARVE_MAX = 4,
    localparam int PW = $clog2(N_PHYS),
    localparam int SW = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cm_valid_i,
    input  logic [PW-1:0] cm_preg_i,
    output logic          cm_ready_o,
    input  logic          sq_valid_i,
    input  logic [PW-1:0] sq_preg_i,
    output logic          sq_ready_o,
    output logic          free_valid_o,
    output logic [PW-1:0] free_preg_o,
    input  logic          alloc_valid_i,
    input  logic [PW-1:0] alloc_preg_i,
    output logic          dup_err_o,
    output logic [SW-1:0] starve_cnt_o
);

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [PW:0]   PREG_LIMIT = (PW + 1)'(N_PHYS);

    logic          cm_nz, sq_nz;
    logic          cm_win, sq_win, grant;
    logic [PW-1:0] grant_preg;
    logic [SW-1:0] starve_d, starve_q;
    logic          free_valid_d, free_valid_q;
    logic [PW-1:0] free_preg_d, free_preg_q;

    // PREG 0 is never freed: zero requests are acked without consuming the grant.
    always_comb begin
        cm_nz      = cm_valid_i && (cm_preg_i != '0);
        sq_nz      = sq_valid_i && (sq_preg_i != '0);
        sq_win     = sq_nz && (!cm_nz || (starve_q == STARVE_LIM));
        cm_win     = cm_nz && !sq_win;
        grant      = cm_win || sq_win;
        grant_preg = sq_win ? sq_preg_i : cm_preg_i;
        cm_ready_o = (cm_valid_i && (cm_preg_i == '0)) || cm_win;
        sq_ready_o = (sq_valid_i && (sq_preg_i == '0)) || sq_win;
    end

    always_comb begin
        starve_d = '0;
        if (cm_win && sq_nz)
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        free_valid_d = grant;
        free_preg_d  = grant ? grant_preg : free_preg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q     <= '0;
            free_valid_q <= 1'b0;
            free_preg_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            free_valid_q <= free_valid_d;
            free_preg_q  <= free_preg_d;
        end
    end

    assign free_valid_o = free_valid_q;
    assign free_preg_o  = free_preg_q;
    assign starve_cnt_o = starve_q;

`ifdef FREE_DUP_CHECK_EN
    // Low N_LOG PREGs hold architectural state at reset; the rest start on the free list.
    localparam int N_LOG = 32;
    localparam logic [N_PHYS-1:0] BITMAP_RST = {{(N_PHYS - N_LOG){1'b1}}, {N_LOG{1'b0}}};

    logic [N_PHYS-1:0] bitmap_d, bitmap_q;
    logic              dup_err_d, dup_err_q;
    logic              same_alloc;

    // A same-cycle alloc of the granted PREG counts as clearing it first, so the free wins cleanly.
    always_comb begin
        bitmap_d   = bitmap_q;
        dup_err_d  = dup_err_q;
        same_alloc = alloc_valid_i && (alloc_preg_i == grant_preg);
        if (alloc_valid_i)
            bitmap_d[alloc_preg_i] = 1'b0;
        if (grant) begin
            if (bitmap_q[grant_preg] && !same_alloc)
                dup_err_d = 1'b1;
            bitmap_d[grant_preg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap_q  <= BITMAP_RST;
            dup_err_q <= 1'b0;
        end else begin
            bitmap_q  <= bitmap_d;
            dup_err_q <= dup_err_d;
        end
    end

    assign dup_err_o = dup_err_q;
`else
    logic alloc_unused;
    assign alloc_unused = alloc_valid_i ^ (^alloc_preg_i);
    assign dup_err_o    = 1'b0;
`endif

    cm_preg_in_range: assert property (@(posedge clk) disable iff (rst)
        cm_valid_i |-> ({1'b0, cm_preg_i} < PREG_LIMIT));
    sq_preg_in_range: assert property (@(posedge clk) disable iff (rst)
        sq_valid_i |-> ({1'b0, sq_preg_i} < PREG_LIMIT));

endmodule

// File: tb/tb_preg_free_arbiter.sv
// Directed scoreboard bench for preg_free_arbiter; dup-check expectations follow FREE_DUP_CHECK_EN.
module tb_preg_free_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cm_valid = 1'b0, sq_valid = 1'b0, alloc_valid = 1'b0;
    logic [5:0] cm_preg = '0, sq_preg = '0, alloc_preg = '0;
    logic       cm_ready_o, sq_ready_o, free_valid_o, dup_err_o;
    logic [5:0] free_preg_o;
    logic [2:0] starve_cnt_o;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [5:0] exp_q[$];
    logic [5:0] last_preg = '0;
    logic       model_dup = 1'b0;
    logic [63:0] model_bm = {{32{1'b1}}, {32{1'b0}}};

    always #5 clk = ~clk;

    preg_free_arbiter #(.N_PHYS(64), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cm_valid_i(cm_valid), .cm_preg_i(cm_preg), .cm_ready_o(cm_ready_o),
        .sq_valid_i(sq_valid), .sq_preg_i(sq_preg), .sq_ready_o(sq_ready_o),
        .free_valid_o(free_valid_o), .free_preg_o(free_preg_o),
        .alloc_valid_i(alloc_valid), .alloc_preg_i(alloc_preg),
        .dup_err_o(dup_err_o), .starve_cnt_o(starve_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/free_valid"}, free_valid_o, 0);
        check({tag, "/free_preg"}, free_preg_o, 0);
        check({tag, "/starve"}, starve_cnt_o, 0);
        check({tag, "/dup_err"}, dup_err_o, 0);
    endtask

    // One clock of stimulus: drive at negedge, check readies, then check registered outputs after posedge.
    task automatic step(input string tag,
                        input logic cv, input logic [5:0] cp,
                        input logic sv, input logic [5:0] sp,
                        input logic ecr, input logic esr,
                        input logic efv, input logic [5:0] efp,
                        input logic [2:0] est);
        logic [5:0] e;
        @(negedge clk);
        cm_valid = cv; cm_preg = cp;
        sq_valid = sv; sq_preg = sp;
        #1;
        check({tag, "/cm_ready"}, cm_ready_o, ecr);
        check({tag, "/sq_ready"}, sq_ready_o, esr);
        if (efv) exp_q.push_back(efp);
`ifdef FREE_DUP_CHECK_EN
        if (efv && model_bm[efp] && !(alloc_valid && alloc_preg == efp)) model_dup = 1'b1;
        if (alloc_valid) model_bm[alloc_preg] = 1'b0;
        if (efv) model_bm[efp] = 1'b1;
`endif
        @(posedge clk);
        #1;
        check({tag, "/free_valid"}, free_valid_o, efv);
        if (efv) begin
            if (exp_q.size() == 0) begin
                check({tag, "/scoreboard_empty"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "/free_preg"}, free_preg_o, e);
                last_preg = e;
            end
        end else begin
            check({tag, "/free_preg_hold"}, free_preg_o, last_preg);
        end
        check({tag, "/starve"}, starve_cnt_o, est);
        check({tag, "/dup_err"}, dup_err_o, model_dup);
    endtask

    // Assert reset in the middle of a cycle and confirm outputs clear without waiting for an edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state(tag);
        cm_valid = 1'b0; sq_valid = 1'b0; alloc_valid = 1'b0;
        exp_q.delete();
        last_preg = '0;
        model_dup = 1'b0;
        model_bm  = {{32{1'b1}}, {32{1'b0}}};
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        step("cm33",  1, 33, 0,  0, 1, 0, 1, 33, 0);

        step("st1",   1, 10, 1,  7, 1, 0, 1, 10, 1);
        step("st2",   1, 11, 1,  7, 1, 0, 1, 11, 2);
        step("st3",   1, 12, 1,  7, 1, 0, 1, 12, 3);
        step("st4",   1, 13, 1,  7, 1, 0, 1, 13, 4);
        step("st_sq", 1, 14, 1,  7, 0, 1, 1,  7, 0);
        step("st_cm", 1, 14, 0,  0, 1, 0, 1, 14, 0);

        step("mid1",  1, 21, 1, 22, 1, 0, 1, 21, 1);
        step("mid2",  1, 23, 1, 22, 1, 0, 1, 23, 2);
        async_reset("midrst");
        step("post1", 1, 24, 1, 22, 1, 0, 1, 24, 1);
        step("sqdrop",1, 25, 0,  0, 1, 0, 1, 25, 0);

        step("cm0sq40",1, 0, 1, 40, 1, 1, 1, 40, 0);
        step("sq0cm20",1, 20, 1, 0, 1, 1, 1, 20, 0);
        step("idle",  0,  0, 0,  0, 0, 0, 0,  0, 0);
        step("both0", 1,  0, 1,  0, 1, 1, 0,  0, 0);
        step("b2b_cm",1, 50, 0,  0, 1, 0, 1, 50, 0);
        step("b2b_sq",0,  0, 1, 51, 0, 1, 1, 51, 0);

        async_reset("duprst1");
        alloc_valid = 1'b1; alloc_preg = 6'd45;
        step("alloc45", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        alloc_valid = 1'b0;
        step("free45a", 1, 45, 0,  0, 1, 0, 1, 45, 0);
        step("free45b", 0,  0, 1, 45, 0, 1, 1, 45, 0);
        step("dupheld", 0,  0, 0,  0, 0, 0, 0,  0, 0);

        async_reset("duprst2");
        alloc_valid = 1'b1; alloc_preg = 6'd45;
        step("allocfree45", 1, 45, 0, 0, 1, 0, 1, 45, 0);
        alloc_valid = 1'b0;
        step("free45c", 1, 45, 0,  0, 1, 0, 1, 45, 0);
        step("idle2",   0,  0, 0,  0, 0, 0, 0,  0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
